// File: rtl/wb_stage_ex_pkg.sv
// Shared definitions for the writeback stage.
//   - exception source indices (bit 0 = highest priority)
//   - ecode / esubcode constants and the index -> {ecode, esubcode} map
//   - FSM state encoding
//   - forwarding bus width helper
package wb_pkg;

    localparam logic [2:0] EXC_INT  = 3'd0;
    localparam logic [2:0] EXC_ADEF = 3'd1;
    localparam logic [2:0] EXC_ALE  = 3'd2;
    localparam logic [2:0] EXC_SYS  = 3'd3;
    localparam logic [2:0] EXC_BRK  = 3'd4;
    localparam logic [2:0] EXC_INE  = 3'd5;
    localparam logic [2:0] EXC_IPE  = 3'd6;
    localparam logic [2:0] EXC_ADEM = 3'd7;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;

    localparam logic [8:0] ESUB_NONE = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_e;

    // Width of the forwarding bus: 5-bit destination plus the data word.
    function automatic int fwd_width(input int xlen);
        return 5 + xlen;
    endfunction

    // Map a winning exception index to {ecode, esubcode}.
    function automatic logic [14:0] exc_code(input logic [2:0] idx);
        logic [14:0] code;
        case (idx)
            EXC_INT:  code = {ECODE_INT, ESUB_NONE};
            EXC_ADEF: code = {ECODE_ADE, ESUB_NONE};
            EXC_ALE:  code = {ECODE_ALE, ESUB_NONE};
            EXC_SYS:  code = {ECODE_SYS, ESUB_NONE};
            EXC_BRK:  code = {ECODE_BRK, ESUB_NONE};
            EXC_INE:  code = {ECODE_INE, ESUB_NONE};
            EXC_IPE:  code = {ECODE_IPE, ESUB_NONE};
            EXC_ADEM: code = {ECODE_ADE, ESUB_ADEM};
            default:  code = {ECODE_INT, ESUB_NONE};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wb_stage_ex_if.sv
// MEM -> WB handoff bundle.
//   master: MEM side, drives in_* and samples wb_allow_in
//   slave : WB side, samples in_* and drives wb_allow_in
interface wb_stage_ex_if #(
    parameter int XLEN    = 32,
    parameter int NUM_EXC = 8
);
    logic                in_valid;
    logic                wb_allow_in;
    logic [XLEN-1:0]     in_pc;
    logic [4:0]          in_dest;
    logic [XLEN-1:0]     in_result;
    logic                in_gr_we;
    logic [NUM_EXC-1:0]  in_exc_vec;
    logic [XLEN-1:0]     in_badv;
    logic                in_ertn;
    logic                in_csr_we;
    logic [13:0]         in_csr_num;
    logic [XLEN-1:0]     in_csr_wmask;
    logic [XLEN-1:0]     in_csr_wdata;

    modport master (
        output in_valid, in_pc, in_dest, in_result, in_gr_we, in_exc_vec,
               in_badv, in_ertn, in_csr_we, in_csr_num, in_csr_wmask, in_csr_wdata,
        input  wb_allow_in
    );

    modport slave (
        input  in_valid, in_pc, in_dest, in_result, in_gr_we, in_exc_vec,
               in_badv, in_ertn, in_csr_we, in_csr_num, in_csr_wmask, in_csr_wdata,
        output wb_allow_in
    );
endinterface

// File: rtl/wb_stage_ex_exc_prio_enc.sv
// Priority encoder for exception sources: the lowest set bit of exc_vec wins.
//   exc_vec  in  NUM_EXC  raw exception flags
//   any      out 1        at least one flag set
//   idx      out 3        index of winning flag (0 when none)
//   ecode    out 6        ecode of winning flag
//   esubcode out 9        esubcode of winning flag
module exc_prio_enc
    import wb_pkg::*;
#(
    parameter int NUM_EXC = 8
) (
    input  logic [NUM_EXC-1:0] exc_vec,
    output logic               any,
    output logic [2:0]         idx,
    output logic [5:0]         ecode,
    output logic [8:0]         esubcode
);

    // Scan from the top down so the lowest set bit is the last to overwrite idx.
    always_comb begin
        idx = 3'd0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            idx = exc_vec[i] ? 3'(i) : idx;
        end
        any               = |exc_vec;
        {ecode, esubcode} = exc_code(idx);
    end

endmodule

// File: rtl/wb_stage_ex.sv
// Writeback stage: commits GPR/CSR writes, raises precise exceptions or ERTN,
// drains the pipe for FLUSH_CYCLES after such a commit, counts retirements.
//   clk, resetn        clock, async active-low reset
//   mem_if (slave)     MEM -> WB handoff (in_* fields, wb_allow_in)
//   rf_*               regfile write port
//   csr_*              CSR write port
//   wb_ex/ecode/...    exception commit and its cause
//   wb_ertn            ERTN commit
//   wb_flushing        high while draining after a commit
//   inst_retired       retired-instruction counter
//   wb_forward         {dest gated by valid, rf_wdata}
//   debug_wb_*         trace port
module wb_stage_ex
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_EXC      = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    wb_stage_ex_if.slave               mem_if,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       csr_we,
    output logic [13:0]                csr_num,
    output logic [XLEN-1:0]            csr_wmask,
    output logic [XLEN-1:0]            csr_wdata,
    output logic                       wb_ex,
    output logic [5:0]                 wb_ecode,
    output logic [8:0]                 wb_esubcode,
    output logic [XLEN-1:0]            wb_pc,
    output logic [XLEN-1:0]            wb_badv,
    output logic                       wb_ertn,
    output logic                       wb_flushing,
    output logic [CNT_W-1:0]           inst_retired,
    output logic [fwd_width(XLEN)-1:0] wb_forward,
    output logic [XLEN-1:0]            debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [XLEN-1:0]            debug_wb_rf_wdata
);

    // Counter only needs to hold FLUSH_CYCLES-1.
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [4:0]         dest;
        logic [XLEN-1:0]    result;
        logic               gr_we;
        logic [NUM_EXC-1:0] exc_vec;
        logic [XLEN-1:0]    badv;
        logic               ertn;
        logic               csr_we;
        logic [13:0]        csr_num;
        logic [XLEN-1:0]    csr_wmask;
        logic [XLEN-1:0]    csr_wdata;
    } fields_t;

    fields_t         f_q, f_d;
    logic            valid_q, valid_d;
    wb_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic            enc_any_s;
    logic [2:0]      enc_idx_s;
    logic [5:0]      enc_ecode_s;
    logic [8:0]      enc_esub_s;
    logic            exc_any_s;
    logic            commit_s;
    logic            capture_s;

    exc_prio_enc #(.NUM_EXC(NUM_EXC)) u_enc (
        .exc_vec  (f_q.exc_vec),
        .any      (enc_any_s),
        .idx      (enc_idx_s),
        .ecode    (enc_ecode_s),
        .esubcode (enc_esub_s)
    );

    assign exc_any_s = valid_q & enc_any_s;
    assign commit_s  = exc_any_s | (valid_q & f_q.ertn);

    // Next-state: capture, drain sequencing and retire count.
    always_comb begin
        f_d       = f_q;
        valid_d   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            RUN: begin
                if (commit_s) begin
                    // The slot right after a commit is always discarded.
                    if (FLUSH_CYCLES > 0) begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    capture_s = mem_if.in_valid;
                end
            end
            FLUSH: begin
                // The final drain cycle already accepts the next instruction,
                // so exactly FLUSH_CYCLES inputs are discarded in total.
                if (cnt_q == '0) begin
                    state_d   = RUN;
                    capture_s = mem_if.in_valid;
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (capture_s) begin
            valid_d = 1'b1;
            f_d     = '{pc:        mem_if.in_pc,
                        dest:      mem_if.in_dest,
                        result:    mem_if.in_result,
                        gr_we:     mem_if.in_gr_we,
                        exc_vec:   mem_if.in_exc_vec,
                        badv:      mem_if.in_badv,
                        ertn:      mem_if.in_ertn,
                        csr_we:    mem_if.in_csr_we,
                        csr_num:   mem_if.in_csr_num,
                        csr_wmask: mem_if.in_csr_wmask,
                        csr_wdata: mem_if.in_csr_wdata};
        end else begin
            valid_d = 1'b0;
        end
        ret_d = ret_q + CNT_W'(valid_q & ~exc_any_s);
    end

    // State, captured fields and retire counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_q     <= '0;
            valid_q <= 1'b0;
            state_q <= RUN;
            cnt_q   <= '0;
            ret_q   <= '0;
        end else begin
            f_q     <= f_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    assign mem_if.wb_allow_in = 1'b1;

    assign wb_ex       = exc_any_s;
    assign wb_ecode    = exc_any_s ? enc_ecode_s : 6'h00;
    assign wb_esubcode = exc_any_s ? enc_esub_s  : 9'h000;
    assign wb_badv     = exc_any_s ? f_q.badv    : {XLEN{1'b0}};
    assign wb_pc       = f_q.pc;
    assign wb_ertn     = valid_q & f_q.ertn & ~exc_any_s;
    assign wb_flushing = (state_q == FLUSH);

    assign rf_we     = valid_q & f_q.gr_we & ~exc_any_s;
    assign rf_waddr  = f_q.dest;
    assign rf_wdata  = f_q.result;
    assign csr_we    = valid_q & f_q.csr_we & ~exc_any_s;
    assign csr_num   = f_q.csr_num;
    assign csr_wmask = f_q.csr_wmask;
    assign csr_wdata = f_q.csr_wdata;

    assign inst_retired = ret_q;
    assign wb_forward   = {(valid_q ? f_q.dest : 5'd0), f_q.result};

    assign debug_wb_pc       = f_q.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = f_q.dest;
    assign debug_wb_rf_wdata = f_q.result;

endmodule

// File: tb/tb_wb_stage_ex.sv
module tb_wb_stage_ex;
    localparam int XLEN = 32, NUM_EXC = 8, FLUSH_CYCLES = 2, CNT_W = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    wb_stage_ex_if #(.XLEN(XLEN), .NUM_EXC(NUM_EXC)) mem_if ();

    logic             rf_we, csr_we, wb_ex, wb_ertn, wb_flushing;
    logic [4:0]       rf_waddr, debug_wb_rf_wnum;
    logic [31:0]      rf_wdata, csr_wmask, csr_wdata, wb_pc, wb_badv;
    logic [31:0]      debug_wb_pc, debug_wb_rf_wdata;
    logic [13:0]      csr_num;
    logic [5:0]       wb_ecode;
    logic [8:0]       wb_esubcode;
    logic [CNT_W-1:0] inst_retired;
    logic [36:0]      wb_forward;
    logic [3:0]       debug_wb_rf_we;

    wb_stage_ex #(.XLEN(XLEN), .NUM_EXC(NUM_EXC), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .mem_if(mem_if.slave),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_badv(wb_badv), .wb_ertn(wb_ertn), .wb_flushing(wb_flushing),
        .inst_retired(inst_retired), .wb_forward(wb_forward),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently in WB plus drain bookkeeping.
    bit          m_valid, m_gr_we, m_ertn, m_csr_we;
    logic [31:0] m_pc, m_result, m_badv, m_wmask, m_wdata;
    logic [4:0]  m_dest;
    logic [7:0]  m_exc;
    logic [13:0] m_csr_num;
    int          m_drop;   // input slots still to be discarded
    int          m_flush;  // cycles of wb_flushing still to show
    longint      m_ret;

    logic [5:0] ecode_tab [8] = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h08};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_gr_we = 0; m_ertn = 0; m_csr_we = 0;
        m_pc = 0; m_result = 0; m_badv = 0; m_wmask = 0; m_wdata = 0;
        m_dest = 0; m_exc = 0; m_csr_num = 0;
        m_drop = 0; m_flush = 0; m_ret = 0;
    endtask

    task automatic model_edge();
        bit committing;
        committing = m_valid && ((m_exc != 8'd0) || m_ertn);
        if (m_valid && m_exc == 8'd0) m_ret = (m_ret + 1) % (64'd1 << CNT_W);
        if (committing) begin
            m_drop  = (FLUSH_CYCLES == 0) ? 1 : FLUSH_CYCLES;
            m_flush = FLUSH_CYCLES;
        end else if (m_flush > 0) begin
            m_flush--;
        end
        if (m_drop > 0) begin
            m_valid = 0;
            m_drop--;
        end else begin
            m_valid = mem_if.in_valid;
            if (mem_if.in_valid) begin
                m_pc = mem_if.in_pc; m_dest = mem_if.in_dest; m_result = mem_if.in_result;
                m_gr_we = mem_if.in_gr_we; m_exc = mem_if.in_exc_vec; m_badv = mem_if.in_badv;
                m_ertn = mem_if.in_ertn; m_csr_we = mem_if.in_csr_we; m_csr_num = mem_if.in_csr_num;
                m_wmask = mem_if.in_csr_wmask; m_wdata = mem_if.in_csr_wdata;
            end
        end
    endtask

    task automatic check_all();
        bit any, we;
        int idx;
        any = m_valid && (m_exc != 8'd0);
        idx = 0;
        for (int i = 7; i >= 0; i--) if (m_exc[i]) idx = i;
        we = m_valid && m_gr_we && !any;
        chk("wb_allow_in", mem_if.wb_allow_in, 1);
        chk("wb_ex", wb_ex, any);
        chk("wb_ecode", wb_ecode, any ? ecode_tab[idx] : 6'h00);
        chk("wb_esubcode", wb_esubcode, (any && idx == 7) ? 1 : 0);
        chk("wb_badv", wb_badv, any ? m_badv : 32'h0);
        chk("wb_pc", wb_pc, m_pc);
        chk("debug_wb_pc", debug_wb_pc, m_pc);
        chk("wb_ertn", wb_ertn, m_valid && m_ertn && !any);
        chk("rf_we", rf_we, we);
        chk("rf_waddr", rf_waddr, m_dest);
        chk("rf_wdata", rf_wdata, m_result);
        chk("debug_wb_rf_we", debug_wb_rf_we, we ? 4'hF : 4'h0);
        chk("debug_wb_rf_wnum", debug_wb_rf_wnum, m_dest);
        chk("debug_wb_rf_wdata", debug_wb_rf_wdata, m_result);
        chk("csr_we", csr_we, m_valid && m_csr_we && !any);
        chk("csr_num", csr_num, m_csr_num);
        chk("csr_wmask", csr_wmask, m_wmask);
        chk("csr_wdata", csr_wdata, m_wdata);
        chk("wb_flushing", wb_flushing, m_flush > 0);
        chk("inst_retired", inst_retired, m_ret);
        chk("wb_forward", wb_forward, {(m_valid ? m_dest : 5'd0), m_result});
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] dest,
                         input logic [31:0] result, input logic gr_we, input logic [7:0] exc,
                         input logic [31:0] badv, input logic ertn, input logic csr_we);
        mem_if.in_valid = v; mem_if.in_pc = pc; mem_if.in_dest = dest;
        mem_if.in_result = result; mem_if.in_gr_we = gr_we; mem_if.in_exc_vec = exc;
        mem_if.in_badv = badv; mem_if.in_ertn = ertn; mem_if.in_csr_we = csr_we;
        mem_if.in_csr_num = 14'($urandom); mem_if.in_csr_wmask = $urandom;
        mem_if.in_csr_wdata = $urandom;
    endtask

    task automatic idle_tick();
        drive(1'b0, $urandom, 5'($urandom), $urandom, 1'b1, 8'($urandom), $urandom, 1'b1, 1'b1);
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all();
        chk("reset_allow_in", mem_if.wb_allow_in, 1);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_retired", inst_retired, 0);
        chk("reset_forward", wb_forward, 0);
        resetn = 1'b1;

        // Plain ALU op
        drive(1'b1, 32'h1c000000, 5'd5, 32'hDEADBEEF, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
        tick();
        chk("alu_rf_we", rf_we, 1);
        chk("alu_rf_waddr", rf_waddr, 5);
        chk("alu_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("alu_dbg_we", debug_wb_rf_we, 4'hF);
        chk("alu_pc", wb_pc, 32'h1c000000);
        chk("alu_ret_before", inst_retired, 0);
        idle_tick();
        chk("alu_ret_after", inst_retired, 1);

        // SYSCALL with writes requested
        drive(1'b1, 32'h1c000004, 5'd6, 32'h1234, 1'b1, 8'b0000_1000, 32'h0, 1'b0, 1'b1);
        tick();
        chk("sys_ex", wb_ex, 1);
        chk("sys_ecode", wb_ecode, 6'h0B);
        chk("sys_esub", wb_esubcode, 0);
        chk("sys_rf_we", rf_we, 0);
        chk("sys_csr_we", csr_we, 0);
        idle_tick();
        chk("sys_ret", inst_retired, 1);
        idle_tick();

        // Multi-hot: ALE beats ADEM
        drive(1'b1, 32'h1c000008, 5'd7, 32'h0, 1'b0, 8'b1000_0100, 32'h10000003, 1'b0, 1'b0);
        tick();
        chk("multi_ecode", wb_ecode, 6'h09);
        chk("multi_esub", wb_esubcode, 0);
        chk("multi_badv", wb_badv, 32'h10000003);
        idle_tick(); idle_tick();

        // Exception followed by three back-to-back instructions
        drive(1'b1, 32'h1c000010, 5'd1, 32'h0, 1'b0, 8'b0010_0000, 32'h0, 1'b0, 1'b0);
        tick();
        chk("drain_ecode", wb_ecode, 6'h0D);
        drive(1'b1, 32'h1c000014, 5'd10, 32'hA, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
        tick();
        chk("drain_flush1", wb_flushing, 1);
        chk("drain_drop1", rf_we, 0);
        drive(1'b1, 32'h1c000018, 5'd11, 32'hB, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
        tick();
        chk("drain_flush2", wb_flushing, 1);
        chk("drain_drop2", rf_we, 0);
        drive(1'b1, 32'h1c00001c, 5'd12, 32'hC, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
        tick();
        chk("drain_flush_end", wb_flushing, 0);
        chk("drain_third_we", rf_we, 1);
        chk("drain_third_addr", rf_waddr, 12);
        idle_tick();
        chk("drain_ret", inst_retired, 2);

        // ERTN with INT: exception wins; then ERTN alone
        drive(1'b1, 32'h1c000020, 5'd0, 32'h0, 1'b0, 8'b0000_0001, 32'h0, 1'b1, 1'b0);
        tick();
        chk("ertn_int_ex", wb_ex, 1);
        chk("ertn_int_ertn", wb_ertn, 0);
        chk("ertn_int_ecode", wb_ecode, 6'h00);
        idle_tick(); idle_tick();
        drive(1'b1, 32'h1c000024, 5'd0, 32'h0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        tick();
        chk("ertn_commit", wb_ertn, 1);
        chk("ertn_no_ex", wb_ex, 0);
        idle_tick();
        chk("ertn_ret", inst_retired, 3);
        chk("ertn_flush", wb_flushing, 1);
        idle_tick(); idle_tick();

        // Reset pulsed in the middle of a drain
        drive(1'b1, 32'h1c000028, 5'd3, 32'h55, 1'b1, 8'b0000_0010, 32'hBAD, 1'b0, 1'b0);
        tick();
        idle_tick();
        chk("rst_pre_flush", wb_flushing, 1);
        #2 resetn = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_flushing", wb_flushing, 0);
        chk("rst_retired", inst_retired, 0);
        chk("rst_pc", wb_pc, 0);
        chk("rst_ex", wb_ex, 0);
        #2 resetn = 1'b1;

        // Counter wrap at 16 retirements
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h1c001000 + 32'(i * 4), 5'(i + 1), 32'(i), 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
            tick();
        end
        chk("wrap_15", inst_retired, 15);
        idle_tick();
        chk("wrap_0", inst_retired, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_tick();
            end else begin
                drive(1'b1, $urandom, 5'($urandom), $urandom, 1'($urandom),
                      ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00,
                      $urandom, ($urandom_range(0, 9) == 0), 1'($urandom));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_stage_ex.md
Name: wb_stage_ex

Overview:
- Parametrised successor writeback stage: final pipeline stage that commits GPR writes and CSR writes, and raises precise exceptions or ERTN.
- Adds over the previous WB generation:
  - multi-source prioritised exception encoding with ecode/esubcode/badv;
  - ERTN commit;
  - a post-flush drain state machine;
  - a retired-instruction counter.
- Sits between MEM stage (valid/allow_in handshake) and the regfile/CSR file. Also drives the debug trace and the forwarding bus.

Parameters:
- XLEN, 32, datapath/PC width.
- NUM_EXC, 8, exception source count (1..8); bit 0 = highest priority.
- FLUSH_CYCLES, 2, cycles input is discarded after an exception/ERTN commit (0 = no drain state).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  MEM->WB valid
- wb_allow_in  out  1  WB can accept
- in_pc  in  XLEN  instruction PC
- in_dest  in  5  GPR destination
- in_result  in  XLEN  writeback data
- in_gr_we  in  1  GPR write request
- in_exc_vec  in  NUM_EXC  exception flags, one-hot or multi-hot
- in_badv  in  XLEN  faulting address
- in_ertn  in  1  instruction is ERTN
- in_csr_we  in  1  CSR write request
- in_csr_num  in  14  CSR index
- in_csr_wmask  in  XLEN  CSR write mask
- in_csr_wdata  in  XLEN  CSR write data
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  XLEN  regfile write port
- csr_we  out  1; csr_num  out  14; csr_wmask  out  XLEN; csr_wdata  out  XLEN  CSR write port
- wb_ex  out  1  exception commit
- wb_ecode  out  6; wb_esubcode  out  9; wb_pc  out  XLEN; wb_badv  out  XLEN
- wb_ertn  out  1  ERTN commit
- wb_flushing  out  1  high while in FLUSH state
- inst_retired  out  CNT_W  retired-instruction count
- wb_forward  out  5+XLEN  {dest gated by valid, rf_wdata}
- debug_wb_pc  out  XLEN; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  XLEN

Behaviour:
- Reset (async, resetn=0): WB_valid=0, FSM=RUN, flush counter=0, inst_retired=0, all captured fields=0. Consequently every output is 0 except wb_allow_in=1.
- Handshake:
  - ready_go is constant 1, so wb_allow_in = 1.
  - Capture: in RUN with in_valid=1, all in_* fields register at the clock edge and WB_valid<=1 next cycle.
  - With in_valid=0, WB_valid<=0.
  - Latency is 1 cycle from MEM handoff to commit outputs.
- Exception encode (combinational on registered fields):
  - exc_any = WB_valid & |exc_vec.
  - Lowest set bit wins.
  - Index to {ecode, esubcode}:
    - 0 INT {0x00,0}
    - 1 ADEF {0x08,0}
    - 2 ALE {0x09,0}
    - 3 SYS {0x0B,0}
    - 4 BRK {0x0C,0}
    - 5 INE {0x0D,0}
    - 6 IPE {0x0E,0}
    - 7 ADEM {0x08,1}
  - wb_ecode, wb_esubcode and wb_badv are 0 when wb_ex=0.
- Commit outputs:
  - wb_ex = exc_any.
  - wb_ertn = WB_valid & ertn & ~exc_any.
  - rf_we = WB_valid & gr_we & ~exc_any.
  - csr_we = WB_valid & csr_we & ~exc_any.
  - rf_waddr, rf_wdata, csr_num, csr_wmask, csr_wdata and wb_pc are driven straight from the registered fields.
- Debug trace: debug_wb_rf_we = {4{rf_we}}, debug_wb_pc = wb_pc.
- FSM RUN→FLUSH:
  - Transition occurs at the edge after a cycle with wb_ex|wb_ertn, when FLUSH_CYCLES>0.
  - On that edge, WB_valid<=0 regardless of in_valid and the counter loads FLUSH_CYCLES-1.
- FSM in FLUSH:
  - wb_flushing=1; in_valid is accepted but discarded (WB_valid stays 0).
  - Counter decrements each cycle; FLUSH→RUN when counter==0.
  - Total discarded cycles = FLUSH_CYCLES.
- FLUSH_CYCLES=0: no FLUSH state, but the cycle immediately after a commit still forces WB_valid<=0.
- Retire counter: +1 on each cycle with WB_valid & ~exc_any; ERTN counts. Wraps modulo 2^CNT_W.
- Simultaneous events:
  - exception + ERTN on the same instruction: the exception wins, wb_ertn=0.
  - exception + gr_we/csr_we: both writes suppressed.
- Reset mid-FLUSH: immediately returns to RUN with the counter cleared.
- wb_forward dest field = rf_waddr when WB_valid, else 0.

Decomposition:
- Shared package wb_pkg holds:
  - exception index localparams (EXC_INT..EXC_ADEM);
  - ecode/esubcode constants;
  - FSM state enum {RUN, FLUSH};
  - forward-bus width function (5+XLEN).
- One sub-module, exc_prio_enc (NUM_EXC), takes exc_vec and outputs any, idx, ecode, esubcode.

Test Plan:
- Plain ALU op: pc=0x1c000000, dest=5, result=0xDEADBEEF, gr_we=1 → next cycle rf_we=1, rf_waddr=5, debug_wb_rf_we=4'hF, inst_retired 0→1.
- SYSCALL: exc_vec=8'b0000_1000, gr_we=1, csr_we=1 → wb_ex=1, ecode=0x0B, esubcode=0, rf_we=0, csr_we=0, inst_retired unchanged.
- Multi-hot exc_vec=8'b1000_0100, badv=0x1000_0003 → ALE wins: ecode=0x09, wb_badv=0x10000003.
- Exception with FLUSH_CYCLES=2 followed by back-to-back valid instructions → wb_flushing high for exactly 2 cycles, both following instructions dropped, third instruction commits.
- ERTN together with exc_vec bit 0 (INT) → wb_ex=1, wb_ertn=0; then ERTN alone → wb_ertn=1, inst_retired+1.
- resetn pulsed low during FLUSH, and counter wrap with CNT_W=4 after 16 retirements → FSM=RUN, all outputs 0 within the reset cycle; inst_retired reads 0 after the 16th retirement.
